// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the LSU and the data-memory controller.
// The LSU side is master; the controller side is slave.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size,
        output req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size,
        input  req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised, byte-enabled data memory with valid/ready handshakes,
// split misaligned accesses, range errors and a post-reset clear sweep.
module dmem_ctrl #(
    parameter int MEM_NBYTE    = 1024,
    parameter int MISALIGN_EN  = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus,
    output logic       init_done
);
    localparam int DEPTH = MEM_NBYTE / 4;
    localparam int AW    = $clog2(MEM_NBYTE);
    localparam int IW    = AW - 2;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACC0, S_ACC1, S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [31:0]    r_mem [DEPTH];
    logic [IW-1:0]  r_clr;
    logic           r_init_done;
    logic [IW-1:0]  r_idx;
    logic [1:0]     r_off;
    logic           r_we;
    logic [1:0]     r_size;
    logic           r_uns;
    logic [31:0]    r_wdata;
    logic           r_err;
    logic [31:0]    r_lo;
    logic [31:0]    r_hi;

    logic           w_acc;
    logic [2:0]     w_nbytes;
    logic [32:0]    w_end;
    logic           w_oor;
    logic           w_cross_in;
    logic           w_err_in;
    logic [3:0]     w_mask;
    logic [7:0]     w_be8;
    logic [63:0]    w_wd64;
    logic           w_cross;
    logic [IW-1:0]  w_idx_hi;
    logic [IW-1:0]  w_widx;
    logic [3:0]     w_wbe;
    logic [31:0]    w_wd;
    logic           w_wr;
    logic [31:0]    w_rd;
    logic [31:0]    w_ext;
    logic           w_resp;

    assign bus.req_ready = (r_state == S_IDLE) && !rst;
    assign w_acc         = bus.req_ready && bus.req_valid;

    always_comb begin
        w_nbytes = 3'd4;
        case (bus.req_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    assign w_end      = {1'b0, bus.req_addr} + 33'(w_nbytes) - 33'd1;
    assign w_oor      = w_end >= 33'(MEM_NBYTE);
    assign w_cross_in = ({1'b0, bus.req_addr[1:0]} + w_nbytes) > 3'd4;
    assign w_err_in   = (bus.req_size == 2'b11) || w_oor
                      || (w_cross_in && (MISALIGN_EN == 0));

    // Lane masks and data for the latched request, spread over two words.
    always_comb begin
        w_mask = 4'b1111;
        case (r_size)
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_be8    = {4'b0000, w_mask} << r_off;
    assign w_wd64   = {32'd0, r_wdata} << {r_off, 3'b000};
    assign w_cross  = |w_be8[7:4];
    assign w_idx_hi = r_idx + 1'b1;
    assign w_widx   = (r_state == S_ACC1) ? w_idx_hi : r_idx;
    assign w_wbe    = (r_state == S_ACC1) ? w_be8[7:4] : w_be8[3:0];
    assign w_wd     = (r_state == S_ACC1) ? w_wd64[63:32] : w_wd64[31:0];
    assign w_wr     = r_we && ((r_state == S_ACC0) || (r_state == S_ACC1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: if (r_clr == IW'(DEPTH - 1)) w_next = S_IDLE;
            S_IDLE: if (w_acc) w_next = w_err_in ? S_RESP : S_ACC0;
            S_ACC0: w_next = w_cross ? S_ACC1 : S_RESP;
            S_ACC1: w_next = S_RESP;
            S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (CLEAR_ON_RST != 0) ? S_INIT : S_IDLE;
            r_clr       <= '0;
            r_init_done <= (CLEAR_ON_RST == 0);
        end else begin
            r_state <= w_next;
            if (r_state == S_INIT) r_clr <= r_clr + 1'b1;
            if (r_state == S_INIT && w_next == S_IDLE) r_init_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_idx   <= bus.req_addr[AW-1:2];
            r_off   <= bus.req_addr[1:0];
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_uns   <= bus.req_unsigned;
            r_wdata <= bus.req_wdata;
            r_err   <= w_err_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) r_mem[r_clr] <= '0;
            if (w_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wbe[b]) r_mem[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
            if (r_state == S_ACC0) r_lo <= r_mem[r_idx];
            if (r_state == S_ACC1) r_hi <= r_mem[w_idx_hi];
        end
    end

    // Bytes above the access size come from r_hi and are dropped by extension.
    assign w_rd = 32'({r_hi, r_lo} >> {r_off, 3'b000});

    always_comb begin
        w_ext = w_rd;
        case (r_size)
            2'b00: w_ext = r_uns ? {24'd0, w_rd[7:0]}
                                 : {{24{w_rd[7]}}, w_rd[7:0]};
            2'b01: w_ext = r_uns ? {16'd0, w_rd[15:0]}
                                 : {{16{w_rd[15]}}, w_rd[15:0]};
            default: w_ext = w_rd;
        endcase
    end

    assign w_resp        = (r_state == S_RESP);
    assign bus.rsp_valid = w_resp;
    assign bus.rsp_err   = w_resp && r_err;
    assign bus.rsp_rdata = (w_resp && !r_err && !r_we) ? w_ext : 32'd0;
    assign init_done     = r_init_done;
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised successor to the single-cycle byte-array data memory. Word-organised, byte-enabled storage behind a valid/ready request and response handshake. Adds optional split handling of misaligned accesses, out-of-range error reporting, response backpressure and a post-reset clear sweep. Sits between the LSU of the multi-cycle/pipelined core and on-chip data RAM.

Parameters:
MEM_NBYTE, 1024, storage size in bytes; power of two, >= 8; DEPTH = MEM_NBYTE/4 words.
MISALIGN_EN, 1, 1 = split word-crossing accesses into two word accesses; 0 = reject them with error.
CLEAR_ON_RST, 1, 1 = zero every word after reset via sweep; 0 = contents untouched by reset.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_addr  in  32  byte address
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 = illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  in  32  store data, LSB-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access rejected, no memory change
init_done  out  1  clear sweep finished / memory usable

Behaviour:
- States: INIT, IDLE, ACC0, ACC1, RESP. Little-endian; word index = addr[log2(MEM_NBYTE)-1:2], offset = addr[1:0].
- rst high at any clock: state <= INIT if CLEAR_ON_RST, else IDLE. Outputs go to req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0 (1 if CLEAR_ON_RST=0). An in-flight request is dropped. A partially written misaligned store may leave its low word written.
- INIT: sweep counter writes 0 to words 0..DEPTH-1, one per cycle. After the last word: init_done=1, state IDLE. Total DEPTH cycles after rst deasserts.
- IDLE: req_ready=1. On accept, latch all req fields and go to ACC0. req_ready=0 in every other state, so at most one request is outstanding.
- Error check at accept: any of these sets err, skips memory and goes straight to RESP:
  - req_size=11
  - addr+bytes-1 >= MEM_NBYTE
  - access crosses a word boundary (offset+bytes > 4) and MISALIGN_EN=0
- ACC0: read or byte-enable write of the low word (bytes offset..min(3, offset+bytes-1)). If the access crosses a word boundary, go to ACC1; else go to RESP.
- ACC1: access word index+1, bytes 0..(offset+bytes-5).
- Reads are synchronous, one cycle. rdata is assembled from the low and high word bytes, then sign/zero-extended per size and unsigned.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stable until rsp_ready. The handshake cycle returns to IDLE, so req_ready rises the next cycle.
- Latency, counted from the accept edge to the first rsp_valid=1 cycle:
  - aligned / non-crossing: 2 cycles
  - crossing: 3 cycles
  - error: 1 cycle
- Half at offset 1 or 2 is non-crossing. Half at offset 3 is crossing. Any word with offset != 0 is crossing.
- Store response: rsp_rdata=0, rsp_err=0. Write visible to any later load.
- Unsigned flag is ignored for word loads and for stores.

Test Plan:
1. rst 1 cycle, CLEAR_ON_RST=1, DEPTH=256 -> init_done rises exactly 256 cycles after rst falls. Load word @0x3FC -> 0x00000000, err=0.
2. Store word 0xDEADBEEF @0x10, then load byte signed @0x11, byte unsigned @0x12, half signed @0x12:
   - required responses: 0xFFFFFFBE, 0x000000AD, 0xFFFFDEAD
   - each response lands 2 cycles after accept.
3. MISALIGN_EN=1: store word 0x11223344 @0x21, then load word @0x21 -> 0x11223344, 3-cycle latency. Word @0x20 reads 0x22334400 if previously 0. Word @0x24 reads 0x00000011.
4. Hold rsp_ready=0 for 5 cycles after load response:
   - rsp_valid, rsp_rdata held stable, req_ready stays 0
   - after rsp_ready=1 for one cycle, req_ready=1 the next cycle.
5. Store half @0x3FF (MEM_NBYTE=1024), size=11 @0x0, and (MISALIGN_EN=0) word @0x2:
   - each gives rsp_err=1, rsp_rdata=0, 1-cycle latency
   - follow-up loads show memory unchanged.
6. Assert rst during ACC0 of a load -> no rsp_valid. After init, memory is zero and the next request is handled normally.
